// File: rtl/piso_32bit.sv
// -----------------------------------------------------------------------------
// piso_32bit
//
// Parallel-in / serial-out shifter for a slow serial debug or peripheral link.
// The block accepts one 32-bit word over a valid/ready handshake. It then
// emits the word one bit at a time on sdo. Each bit is held for BIT_CYCLES
// clocks. A one-cycle done pulse follows the final bit.
//
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both high. load_ready is high only in IDLE and depends on
// state alone. The producer keeps load_valid, d and msb_first stable until it
// sees load_ready. d and msb_first are not looked at outside that edge.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  producer presents a word on d
//   load_ready  block can take a word (IDLE only)
//   d           32-bit word to serialise
//   msb_first   bit order captured with d (1: bit 31 first, 0: bit 0 first)
//   abort       synchronous cancel of a transfer in progress
//   sdo         serial data out
//   sdo_valid   sdo carries a payload bit
//   busy        transfer in progress
//   done        one-cycle pulse after the last bit's hold period
//   fsm_state   current FSM state, for debug visibility
//
// Parameters
//   BIT_CYCLES  clocks each bit is held on sdo (1..256)
// -----------------------------------------------------------------------------
module piso_32bit #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] d,
    input  logic        msb_first,
    input  logic        abort,
    output logic        sdo,
    output logic        sdo_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The hold counter runs 0..BIT_CYCLES-1. This fits in 8 bits for the
    // whole legal range of BIT_CYCLES.
    localparam logic [7:0] HOLD_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [5:0] BIT_LAST  = 6'd31;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic        order_q, order_d;   // captured msb_first
    logic [5:0]  bit_q,   bit_d;
    logic [7:0]  hold_q,  hold_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            order_q <= 1'b0;
            bit_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            order_q <= order_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        order_d = order_q;
        bit_d   = bit_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                // load_ready is high throughout IDLE. So load_valid alone
                // marks the handshake, and abort has no effect here.
                if (load_valid) begin
                    shreg_d = d;
                    order_d = msb_first;
                    bit_d   = '0;
                    hold_d  = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    shreg_d = '0;
                    bit_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    // The current bit's hold period ends on this edge. Move
                    // the next bit to the output end and back-fill with zero.
                    hold_d  = '0;
                    shreg_d = order_q ? (shreg_q << 1) : (shreg_q >> 1);
                    bit_d   = bit_q + 6'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end

            DONE: begin
                // Exactly one cycle long. abort is ignored, so done always
                // completes once reached.
                state_d = IDLE;
                bit_d   = '0;
                hold_d  = '0;
            end

            default: begin
                state_d = IDLE;
                shreg_d = '0;
                bit_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        load_ready = 1'b0;
        sdo        = 1'b0;
        sdo_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                busy      = 1'b1;
                sdo_valid = 1'b1;
                sdo       = order_q ? shreg_q[31] : shreg_q[0];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_piso_32bit.sv
// -----------------------------------------------------------------------------
// tb_piso_32bit
//
// Two instances share one clock and reset: u_dut4 with BIT_CYCLES=4 and
// u_dut1 with BIT_CYCLES=1. The variable sel routes the handshake and abort
// inputs to one instance and picks which outputs are observed. Expected serial
// streams come from the word and bit order alone. Each bit is repeated
// BIT_CYCLES times into a queue, and the queue is popped once per cycle.
// -----------------------------------------------------------------------------
module tb_piso_32bit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        lv;
    logic [31:0] d;
    logic        msb;
    logic        ab;
    int          sel;

    logic        lv4, ab4, lv1, ab1;
    logic        lr4, sdo4, sv4, busy4, done4;
    logic        lr1, sdo1, sv1, busy1, done1;
    logic [1:0]  st4, st1;
    logic        o_lr, o_sdo, o_sv, o_busy, o_done;

    assign lv4 = lv && (sel == 0);
    assign ab4 = ab && (sel == 0);
    assign lv1 = lv && (sel == 1);
    assign ab1 = ab && (sel == 1);

    assign o_lr   = (sel == 1) ? lr1   : lr4;
    assign o_sdo  = (sel == 1) ? sdo1  : sdo4;
    assign o_sv   = (sel == 1) ? sv1   : sv4;
    assign o_busy = (sel == 1) ? busy1 : busy4;
    assign o_done = (sel == 1) ? done1 : done4;

    piso_32bit #(.BIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_ready(lr4),
        .d(d), .msb_first(msb), .abort(ab4), .sdo(sdo4), .sdo_valid(sv4),
        .busy(busy4), .done(done4), .fsm_state(st4)
    );

    piso_32bit #(.BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1),
        .d(d), .msb_first(msb), .abort(ab1), .sdo(sdo1), .sdo_valid(sv1),
        .busy(busy1), .done(done1), .fsm_state(st1)
    );

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Enter and leave at a falling edge with the selected instance in IDLE.
    // cut_kind: 0 = full transfer, 1 = abort at bit cut_bit,
    // 2 = reset at bit cut_bit. After the handshake, load_valid and d become
    // next_lv and next_d, and msb_first is inverted. None of these may
    // disturb the word already in flight.
    task automatic run_word(input logic [31:0] w, input logic ord, input int cut_bit,
                            input int cut_kind, input logic next_lv, input logic [31:0] next_d);
        int bc;
        bc = (sel == 1) ? 1 : 4;
        exp_q.delete();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < bc; j++)
                exp_q.push_back(ord ? w[31 - i] : w[i]);

        lv  = 1'b1;
        d   = w;
        msb = ord;
        chk("hs_ready", o_lr, 1);
        @(posedge clk);
        @(negedge clk);
        lv  = next_lv;
        d   = next_d;
        msb = ~ord;

        for (int k = 1; k <= 32 * bc; k++) begin
            logic e;
            e = exp_q.pop_front();
            chk($sformatf("sdo_k%0d", k), o_sdo, e);
            chk("shift_valid", o_sv, 1);
            chk("shift_busy", o_busy, 1);
            chk("shift_ready", o_lr, 0);
            chk("shift_done", o_done, 0);
            if (cut_kind != 0 && k == cut_bit * bc + 1) begin
                if (cut_kind == 1) begin
                    ab = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    ab = 1'b0;
                    chk("abort_valid", o_sv, 0);
                    chk("abort_busy", o_busy, 0);
                    chk("abort_done", o_done, 0);
                    chk("abort_ready", o_lr, 1);
                    @(negedge clk);
                    chk("abort_done_later", o_done, 0);
                    chk("abort_ready_later", o_lr, 1);
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_sdo", o_sdo, 0);
                    chk("rst_valid", o_sv, 0);
                    chk("rst_busy", o_busy, 0);
                    chk("rst_done", o_done, 0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    chk("rst_done_held", o_done, 0);
                    @(negedge clk);
                    chk("rst_ready", o_lr, 1);
                end
                lv = 1'b0;
                return;
            end
            @(negedge clk);
        end

        // cycle 32*bc+1: DONE
        chk("done_pulse", o_done, 1);
        chk("done_busy", o_busy, 0);
        chk("done_valid", o_sv, 0);
        chk("done_sdo", o_sdo, 0);
        chk("done_ready", o_lr, 0);
        @(negedge clk);
        // cycle 32*bc+2: back in IDLE
        chk("post_ready", o_lr, 1);
        chk("post_done", o_done, 0);
        chk("post_valid", o_sv, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] w;
        logic        o;
        rst_n = 1'b0;
        lv    = 1'b0;
        d     = '0;
        msb   = 1'b0;
        ab    = 1'b0;
        sel   = 0;

        // Reset, then stay idle
        repeat (3) @(negedge clk);
        chk("rst_sdo4", sdo4, 0);
        chk("rst_valid4", sv4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready4", lr4, 1);
            chk("idle_busy4", busy4, 0);
            chk("idle_valid4", sv4, 0);
            chk("idle_done4", done4, 0);
            chk("idle_sdo4", sdo4, 0);
            chk("idle_ready1", lr1, 1);
            chk("idle_busy1", busy1, 0);
            chk("idle_valid1", sv1, 0);
            chk("idle_done1", done1, 0);
        end

        // LSB-first, BIT_CYCLES=4
        sel = 0;
        run_word(32'hA5A5_0F0F, 1'b0, -1, 0, 1'b0, 32'h0);

        // MSB-first, BIT_CYCLES=1, d scrambled mid-transfer
        sel = 1;
        run_word(32'h8000_0001, 1'b1, -1, 0, 1'b0, 32'hFFFF_FFFF);

        // load_valid held through a busy transfer
        sel = 0;
        run_word(32'h1234_5678, 1'b0, -1, 0, 1'b1, 32'hDEAD_BEEF);
        run_word(32'hDEAD_BEEF, 1'b0, -1, 0, 1'b0, 32'h0);

        // Abort at bit 10, then a fresh transfer
        w = $urandom();
        o = 1'($urandom_range(0, 1));
        run_word(w, o, 10, 1, 1'b0, 32'h0);
        w = $urandom();
        run_word(w, ~o, -1, 0, 1'b0, $urandom());

        // Reset at bit 20, then a fresh word
        w = $urandom();
        run_word(w, 1'b1, 20, 2, 1'b0, 32'h0);
        run_word(32'h0000_0003, 1'b0, -1, 0, 1'b0, 32'h0);

        // Random words on both instances
        for (int i = 0; i < 6; i++) begin
            sel = i % 2;
            w = $urandom();
            o = 1'($urandom_range(0, 1));
            run_word(w, o, -1, 0, 1'($urandom_range(0, 1)), $urandom());
            lv = 1'b0;
            @(negedge clk);
        end

        // Abort on the BIT_CYCLES=1 instance
        sel = 1;
        w = $urandom();
        run_word(w, 1'b0, $urandom_range(0, 31), 1, 1'b0, 32'h0);
        run_word($urandom(), 1'b1, -1, 0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_32bit.md
Name: piso_32bit

Overview:
- Parallel-in/serial-out 32-bit shifter: the read-out counterpart of the parallel-load enable register.
- Accepts one 32-bit word over a valid/ready handshake and emits it one bit at a time on a serial data line, holding each bit for BIT_CYCLES clocks.
- Sits between the datapath and a slow serial debug/peripheral link.
- Pulses done when the last bit's hold period completes.

Parameters:
- BIT_CYCLES, 4, clocks each serial bit is held on sdo (legal range 1..256).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  producer has a word on d
- load_ready  output  1  block can accept a word (IDLE only)
- d  input  32  parallel word to serialise
- msb_first  input  1  bit order, sampled with d at acceptance (1 = bit 31 first, 0 = bit 0 first)
- abort  input  1  synchronous cancel of an in-progress transfer
- sdo  output  1  serial data out
- sdo_valid  output  1  sdo carries a payload bit
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the final bit completes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift register, bit counter and hold counter = 0.
  - sdo=0, sdo_valid=0, busy=0, done=0.
  - load_ready=1 once rst_n deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, busy=0, sdo_valid=0, sdo=0.
  - A handshake is load_valid && load_ready on a rising edge.
  - On handshake: capture d and msb_first, clear counters, go to SHIFT.
- SHIFT:
  - load_ready=0, busy=1, sdo_valid=1.
  - sdo = shreg[31] if msb_first was captured as 1, else shreg[0].
  - Hold counter runs 0..BIT_CYCLES-1.
  - When the hold counter reaches BIT_CYCLES-1:
    - shift the register toward the output end, filling with 0;
    - increment the bit counter (6 bits) and reset the hold counter.
  - When bit counter = 31 and hold counter = BIT_CYCLES-1: go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, sdo_valid=0, sdo=0, load_ready=0.
  - Next state is IDLE.
- Latency:
  - First bit appears on sdo the cycle after the handshake.
  - Payload window is exactly 32*BIT_CYCLES cycles.
  - done asserts on cycle 32*BIT_CYCLES+1 after the handshake.
  - load_ready reasserts one cycle after done.
  - Back-to-back throughput is one word per 32*BIT_CYCLES+2 cycles.
- BIT_CYCLES=1: the hold counter is effectively constant and one bit shifts per clock; behaviour is otherwise identical.
- d and msb_first are ignored outside the handshake cycle; changing them mid-transfer has no effect.
- load_valid asserted while busy is not accepted. The producer holds load_valid until it sees load_ready.
- abort:
  - In SHIFT: go to IDLE on the next edge with no done pulse; sdo_valid drops the same edge and counters clear.
  - In IDLE or DONE: ignored. DONE still completes to IDLE, and done still pulses.
  - abort and load_valid together in IDLE: the handshake is taken (abort ignored).
- Reset mid-transfer: immediate return to reset values; no done pulse; the partially sent word is lost.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs except load_ready, which depends on state only.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release → load_ready=1, busy=0, sdo_valid=0, done=0; no change for 10 idle cycles.
- LSB-first with BIT_CYCLES=4: load d=32'hA5A5_0F0F, msb_first=0.
  - sdo sequence 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, each held 4 cycles.
  - done pulses at cycle 129 after the handshake; load_ready=1 at cycle 130.
- MSB-first with BIT_CYCLES=1: load d=32'h8000_0001, msb_first=1.
  - sdo=1 on the first bit, 0 for the next 30, 1 on the 32nd.
  - done at cycle 33; d changed to 32'hFFFF_FFFF mid-transfer does not alter the output.
- Busy rejection: hold load_valid=1 continuously with d=32'h1234_5678, then 32'hDEAD_BEEF.
  - Second word is accepted only after done plus one cycle.
  - Exactly two transfers of 32*BIT_CYCLES cycles each, separated by one DONE cycle and one IDLE cycle.
- Abort: assert abort for 1 cycle at bit 10 of a transfer → sdo_valid=0 and busy=0 next cycle, no done pulse, load_ready=1; a new load then serialises correctly from bit 0.
- Reset mid-transfer: drop rst_n at bit 20 → sdo=0, sdo_valid=0, busy=0 immediately (asynchronous); after release, a fresh word 32'h0000_0003 with msb_first=0 emits 1,1, then 30 zeros.
